// File: rtl/r_encoder_if.sv
// Request and instruction-memory write bus of the LEGv8 R-format encoder.
interface r_encoder_if #(
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_func;
    logic [4:0]        req_rd;
    logic [4:0]        req_rn;
    logic [4:0]        req_rm;
    logic [5:0]        req_shamt;
    logic              req_err;
    logic              mem_stall;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data;
    logic [ADDR_W-1:0] word_count;
    logic              halted;

    modport slave (
        input  req_valid, req_func, req_rd, req_rn, req_rm, req_shamt, mem_stall,
        output req_ready, req_err, mem_write, mem_addr, mem_data, word_count, halted
    );

    modport master (
        output req_valid, req_func, req_rd, req_rn, req_rm, req_shamt, mem_stall,
        input  req_ready, req_err, mem_write, mem_addr, mem_data, word_count, halted
    );
endinterface

// File: rtl/r_encoder.sv
// Encodes LEGv8 R-format instruction words, queues them in a FIFO and streams
// them into instruction memory at consecutive word addresses until MAX_WORDS.
module r_encoder #(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 16,
    parameter int BASE_ADDR = 0,
    parameter int MAX_WORDS = 1024
) (
    input logic        clock,
    input logic        reset,
    input logic        restart,
    r_encoder_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MAX_WORDS - 1);
    localparam logic [PTR_W:0]    LEVEL_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]    LEVEL_MAX = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WRITE, HALT} state_e;

    typedef enum logic [3:0] {
        F_AND, F_ANDS, F_ORR, F_EOR, F_ADD, F_ADDS, F_SUB, F_SUBS, F_LSL, F_LSR
    } func_e;

    function automatic logic [31:0] encode(input logic [3:0] func,
                                           input logic [4:0] rd, input logic [4:0] rn,
                                           input logic [4:0] rm, input logic [5:0] shamt);
        logic [10:0] op;
        logic        shift;
        op    = '0;
        shift = 1'b0;
        case (func_e'(func))
            F_AND:   op = 11'b10001010000;
            F_ANDS:  op = 11'b11101010000;
            F_ORR:   op = 11'b10101010000;
            F_EOR:   op = 11'b11001010000;
            F_ADD:   op = 11'b10001011000;
            F_ADDS:  op = 11'b10101011000;
            F_SUB:   op = 11'b11001011000;
            F_SUBS:  op = 11'b11101011000;
            F_LSL:   begin op = 11'b11010011011; shift = 1'b1; end
            F_LSR:   begin op = 11'b11010011010; shift = 1'b1; end
            default: op = '0;
        endcase
        // Shifts carry shamt with Rm zeroed; everything else carries Rm with shamt zeroed.
        return shift ? {op, 5'd0, shamt, rn, rd} : {op, rm, 6'd0, rn, rd};
    endfunction

    state_e            state, state_next;
    logic [31:0]       fifo_mem [DEPTH];
    logic [PTR_W:0]    wr_ptr, rd_ptr, fifo_level;
    logic              fifo_empty, fifo_full;
    logic              legal, accept, push, pop;
    logic [ADDR_W-1:0] addr_q, count_q;
    logic              err_q;

    assign fifo_level = wr_ptr - rd_ptr;
    assign fifo_empty = (fifo_level == '0);
    assign fifo_full  = (fifo_level == LEVEL_MAX);
    assign legal      = (bus.req_func <= 4'd9);

    // A same-cycle pop never frees a slot for a push: ready looks only at the registered level.
    assign bus.req_ready = ~fifo_full & (state != HALT);
    assign accept        = bus.req_valid & bus.req_ready;
    assign push          = accept & legal;
    assign pop           = (state == WRITE) & ~bus.mem_stall;

    assign bus.mem_write  = (state == WRITE);
    assign bus.halted     = (state == HALT);
    assign bus.mem_addr   = addr_q;
    assign bus.word_count = count_q;
    assign bus.req_err    = err_q;
    assign bus.mem_data   = (state == WRITE) ? fifo_mem[rd_ptr[PTR_W-1:0]] : '0;

    // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (!fifo_empty) state_next = WRITE;
            WRITE: begin
                if (pop) begin
                    if (count_q == LAST_WORD)                 state_next = HALT;
                    else if (fifo_level == LEVEL_ONE && !push) state_next = IDLE;
                end
            end
            HALT:    state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the storage array has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= encode(bus.req_func, bus.req_rd, bus.req_rn,
                                                        bus.req_rm, bus.req_shamt);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset || restart) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            addr_q  <= ADDR_W'(BASE_ADDR);
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_next;
            err_q <= accept & ~legal;
            if (push) wr_ptr <= wr_ptr + LEVEL_ONE;
            if (pop) begin
                rd_ptr  <= rd_ptr + LEVEL_ONE;
                addr_q  <= addr_q + ADDR_W'(4);
                count_q <= count_q + ADDR_W'(1);
            end
        end
    end
endmodule
